// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues instmem reads and buffers the returned words
// in a 2-entry FIFO for the decoder. Optional fetch counter enabled by FETCH_PERF_EN.
`ifndef INSTMEM_ADDR_WIDTH
`define INSTMEM_ADDR_WIDTH 8
`endif
`ifndef INSTMEM_WORDSIZE
`define INSTMEM_WORDSIZE 32
`endif

module inst_fetch_ctrl #(
    parameter int unsigned ADDR_W = `INSTMEM_ADDR_WIDTH,
    parameter int unsigned WORD_W = `INSTMEM_WORDSIZE,
    parameter int unsigned OPC_W  = 4,
    parameter logic [OPC_W-1:0]  HALT_OPC = 4'hF,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
`ifdef FETCH_PERF_EN
    output logic [15:0]       fetch_count,
`endif
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              in_flight_q, in_flight_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_inst_q, out_inst_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [WORD_W-1:0] skid_inst_q, skid_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;

    logic       run_s, start_ok_s, branch_s, deq_s, halt_s, flush_s, push_s, issue_s;
    logic [1:0] occ_s;

    // Control decode: a branch overrides any same-cycle acceptance, including a halt word
    always_comb begin
        run_s      = (state_q == ST_RUN);
        start_ok_s = start & (state_q != ST_RUN);
        branch_s   = run_s & br_valid;
        deq_s      = run_s & out_valid_q & out_ready & ~branch_s;
        halt_s     = deq_s & (out_inst_q[WORD_W-1 -: OPC_W] == HALT_OPC);
        flush_s    = branch_s | halt_s;
        push_s     = in_flight_q & ~flush_s;
        occ_s      = {1'b0, out_valid_q} + {1'b0, skid_valid_q}
                   + {1'b0, in_flight_q} - {1'b0, deq_s};
        issue_s    = run_s & ~flush_s & (occ_s < 2'd2);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = start ? ST_RUN : ST_IDLE;
            ST_RUN:    state_d = (halt_s && !branch_s) ? ST_HALTED : ST_RUN;
            ST_HALTED: state_d = start ? ST_RUN : ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy   = (state_q == ST_RUN);
        halted = (state_q == ST_HALTED);
    end

    // PC, issue and FIFO next values; the output register is always filled before the skid
    always_comb begin
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        in_flight_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        if (start_ok_s) begin
            pc_d         = start_addr;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (flush_s) begin
            pc_d         = branch_s ? br_target : pc_q;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (run_s) begin
            if (deq_s && skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_inst_d   = skid_inst_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = push_s;
                skid_inst_d  = push_s ? mem_q : skid_inst_q;
                skid_pc_d    = push_s ? mem_addr_q : skid_pc_q;
            end else if (deq_s || !out_valid_q) begin
                out_valid_d  = push_s;
                out_inst_d   = push_s ? mem_q : out_inst_q;
                out_pc_d     = push_s ? mem_addr_q : out_pc_q;
            end else if (push_s) begin
                skid_valid_d = 1'b1;
                skid_inst_d  = mem_q;
                skid_pc_d    = mem_addr_q;
            end else begin
                skid_valid_d = skid_valid_q;
            end
            if (issue_s) begin
                mem_addr_d  = pc_q;
                pc_d        = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                in_flight_d = 1'b1;
            end else begin
                in_flight_d = 1'b0;
            end
        end else begin
            in_flight_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            mem_addr_q   <= RESET_PC;
            in_flight_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_inst_q   <= {WORD_W{1'b0}};
            out_pc_q     <= {ADDR_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_inst_q  <= {WORD_W{1'b0}};
            skid_pc_q    <= {ADDR_W{1'b0}};
        end else begin
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            in_flight_q  <= in_flight_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    // Saturating count of accepted words; flushed words never reach deq
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (start_ok_s) begin
            fetch_count_d = 16'h0000;
        end else if (deq_s && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'h0001;
        end else begin
            fetch_count_d = fetch_count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count_q <= 16'h0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl (ADDR_W = 8, WORD_W = 32).
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready, br_valid;
    logic [7:0]  start_addr, br_target, mem_addr, out_pc;
    logic [31:0] mem_q, out_inst;
    logic        out_valid, busy, halted;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
`endif

    logic [31:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Memory whose output reflects the registered address (one cycle after issue)
    assign mem_q = mem[mem_addr];

    inst_fetch_ctrl #(.ADDR_W(8), .WORD_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .mem_addr(mem_addr), .mem_q(mem_q), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
        .br_valid(br_valid), .br_target(br_target),
`ifdef FETCH_PERF_EN
        .fetch_count(fetch_count),
`endif
        .busy(busy), .halted(halted)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_pc"}, {56'd0, out_pc}, {56'd0, pc});
        chk({tag, "_inst"}, {32'd0, out_inst}, {32'd0, inst});
    endtask

    initial begin
        logic [31:0] exp_word [4];
        int          exp_pc, last_acc;
        logic        stalled;
        logic [31:0] prev_inst;
        logic [7:0]  prev_pc;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0A00_0000 | i;
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222;
        mem[2] = 32'h3333_3333; mem[3] = 32'hF000_0000;
        exp_word[0] = 32'h1111_1111; exp_word[1] = 32'h2222_2222;
        exp_word[2] = 32'h3333_3333; exp_word[3] = 32'hF000_0000;

        rst_n = 1'b0; start = 1'b0; start_addr = 8'h00; out_ready = 1'b1;
        br_valid = 1'b0; br_target = 8'h00;
        tick(); tick();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_addr", {56'd0, mem_addr}, 64'd0);
        chk("rst_inst", {32'd0, out_inst}, 64'd0);
        chk("rst_pc", {56'd0, out_pc}, 64'd0);
        rst_n = 1'b1;

        // Branch in IDLE is ignored
        br_valid = 1'b1; br_target = 8'h20;
        tick();
        br_valid = 1'b0;
        tick();
        chk("idle_br_busy", {63'd0, busy}, 64'd0);
        chk("idle_br_addr", {56'd0, mem_addr}, 64'd0);

        // Straight-line run to halt
        start = 1'b1; start_addr = 8'h00;
        tick(); start = 1'b0;
        chk("s1_busy", {63'd0, busy}, 64'd1);
        chk("s1_e0_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("s1_e1_addr", {56'd0, mem_addr}, 64'd0);
        chk("s1_e1_valid", {63'd0, out_valid}, 64'd0);
        tick(); chk_out("s1_w0", 8'h00, 32'h1111_1111);
        tick(); chk_out("s1_w1", 8'h01, 32'h2222_2222);
        tick(); chk_out("s1_w2", 8'h02, 32'h3333_3333);
        tick(); chk_out("s1_w3", 8'h03, 32'hF000_0000);
        tick();
        chk("s1_halted", {63'd0, halted}, 64'd1);
        chk("s1_nbusy", {63'd0, busy}, 64'd0);
        chk("s1_nvalid", {63'd0, out_valid}, 64'd0);
        tick(); tick();
        chk("s1_still_nvalid", {63'd0, out_valid}, 64'd0);
        chk("s1_addr_frozen", {56'd0, mem_addr}, 64'd4);
`ifdef FETCH_PERF_EN
        chk("s1_count", {48'd0, fetch_count}, 64'd4);
`endif

        // out_ready pattern 1,0,0,1,0,0,...
        start = 1'b1; start_addr = 8'h00;
        tick(); start = 1'b0;
`ifdef FETCH_PERF_EN
        chk("s2_count_clr", {48'd0, fetch_count}, 64'd0);
`endif
        exp_pc = 0; last_acc = -1;
        out_ready = 1'b1;
        for (int k = 1; k < 60; k++) begin
            if (out_valid && out_ready) begin
                chk("s2_acc_pc", {56'd0, out_pc}, exp_pc);
                chk("s2_acc_inst", {32'd0, out_inst}, {32'd0, exp_word[exp_pc & 3]});
                last_acc = exp_pc;
                exp_pc++;
            end
            stalled = out_valid && !out_ready;
            prev_inst = out_inst; prev_pc = out_pc;
            tick();
            if (stalled) begin
                chk("s2_stall_valid", {63'd0, out_valid}, 64'd1);
                chk("s2_stall_inst", {32'd0, out_inst}, {32'd0, prev_inst});
                chk("s2_stall_pc", {56'd0, out_pc}, {56'd0, prev_pc});
            end
            if (busy) chk("s2_ahead", {63'd0, (int'(mem_addr) - last_acc) <= 2}, 64'd1);
            if (halted) break;
            out_ready = (k % 3 == 0);
        end
        chk("s2_count_words", exp_pc, 64'd4);
        chk("s2_halted", {63'd0, halted}, 64'd1);
        out_ready = 1'b1;

        // Branch while pc 2 is presented
        start = 1'b1; start_addr = 8'h00;
        tick(); start = 1'b0;
        tick();
        tick(); chk_out("s3_w0", 8'h00, 32'h1111_1111);
        tick(); chk_out("s3_w1", 8'h01, 32'h2222_2222);
        tick(); chk_out("s3_w2", 8'h02, 32'h3333_3333);
        br_valid = 1'b1; br_target = 8'h10;
        tick(); br_valid = 1'b0;
        chk("s3_flush_valid", {63'd0, out_valid}, 64'd0);
        chk("s3_flush_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("s3_issue_valid", {63'd0, out_valid}, 64'd0);
        chk("s3_issue_addr", {56'd0, mem_addr}, 64'h10);
        tick(); chk_out("s3_t0", 8'h10, 32'h0A00_0010);
        tick(); chk_out("s3_t1", 8'h11, 32'h0A00_0011);

        // Reset mid-run
        rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        chk("s4_valid", {63'd0, out_valid}, 64'd0);
        chk("s4_busy", {63'd0, busy}, 64'd0);
        chk("s4_addr", {56'd0, mem_addr}, 64'd0);
        chk("s4_halted", {63'd0, halted}, 64'd0);
        start = 1'b1; start_addr = 8'h00;
        tick(); start = 1'b0;
        tick();
        tick(); chk_out("s4_w0", 8'h00, 32'h1111_1111);
        tick(); chk_out("s4_w1", 8'h01, 32'h2222_2222);
        start = 1'b1; start_addr = 8'h40;   // start while running must be ignored
        tick(); start = 1'b0;
        chk_out("s4_w2", 8'h02, 32'h3333_3333);
        tick(); chk_out("s4_w3", 8'h03, 32'hF000_0000);
        tick();
        chk("s4_halted_end", {63'd0, halted}, 64'd1);
`ifdef FETCH_PERF_EN
        chk("s4_count", {48'd0, fetch_count}, 64'd4);
`endif

        // PC wrap from 0xFE
        start = 1'b1; start_addr = 8'hFE;
        tick(); start = 1'b0;
`ifdef FETCH_PERF_EN
        chk("s5_count_clr", {48'd0, fetch_count}, 64'd0);
`endif
        tick();
        tick(); chk_out("s5_fe", 8'hFE, 32'h0A00_00FE);
        tick(); chk_out("s5_ff", 8'hFF, 32'h0A00_00FF);
        tick(); chk_out("s5_00", 8'h00, 32'h1111_1111);
        tick(); chk_out("s5_01", 8'h01, 32'h2222_2222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction fetch sequencer for the tinyGPU core.
- Owns the program counter, drives the address input of the instruction memory (instmem: synchronous read, 1-cycle latency) and buffers the returned words.
- Presents instructions to the decoder over a valid/ready handshake, with branch redirect and halt detection.
- Sits between instmem and the decode stage.

Parameters:
- ADDR_W, `INSTMEM_ADDR_WIDTH: PC / memory address width.
- WORD_W, `INSTMEM_WORDSIZE: instruction width.
- OPC_W, 4: opcode field width, located at bits [WORD_W-1 : WORD_W-OPC_W].
- HALT_OPC, 4'hF: opcode value that halts fetch.
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle pulse; begin fetching at start_addr (honoured in IDLE or HALTED only).
- start_addr  in  ADDR_W  first fetch address.
- mem_addr  out  ADDR_W  registered address to instmem.
- mem_q  in  WORD_W  instmem data; holds the word for the mem_addr value sampled at the previous edge.
- out_valid  out  1  out_inst/out_pc valid.
- out_ready  in  1  decoder accepts when out_valid & out_ready.
- out_inst  out  WORD_W  instruction word.
- out_pc  out  ADDR_W  address of out_inst.
- br_valid  in  1  redirect request (honoured in RUN only).
- br_target  in  ADDR_W  redirect address.
- busy  out  1  high in RUN.
- halted  out  1  high in HALTED.

Behaviour:
- Reset: state = IDLE, pc = RESET_PC, mem_addr = RESET_PC, out_valid = 0, out_inst = 0, out_pc = 0, busy = 0, halted = 0. Buffer and in-flight flag are cleared.
- Reset mid-operation overrides every other input in the same cycle.
- States:
  - IDLE: start -> RUN, pc <= start_addr.
  - RUN: fetching.
    - Accepted halt word -> HALTED.
    - br_valid -> stays RUN with redirect.
  - HALTED: start -> RUN, pc <= start_addr, halted cleared. Otherwise hold.
- Issue:
  - In RUN, one address is issued per cycle when (buffered + in_flight - deq) < 2, where deq = out_valid & out_ready.
  - Issue means mem_addr <= pc, pc <= pc + 1 modulo 2^ADDR_W (0xFF wraps to 0x00 for ADDR_W = 8), in_flight <= 1.
  - The tag for out_pc is held alongside.
- Data return: one cycle after issue, mem_q with its pc tag enters a 2-entry FIFO (output register + skid). The output register is filled first.
- Buffer depth 2 sustains 1 instruction/cycle with out_ready high. With out_ready low, there is no loss and no duplication.
- First out_valid appears 2 cycles after the start edge: start edge -> issue edge -> data captured.
- Branch (br_valid in RUN):
  - Buffer flushed; the in-flight return is discarded.
  - out_valid = 0 the next cycle.
  - pc <= br_target; the first issue of br_target occurs on the following edge.
  - Branch beats a same-cycle deq of any word, including a halt word: the state stays RUN.
- Halt: when a word whose opcode == HALT_OPC is accepted (deq), state -> HALTED.
  - The halt word itself is delivered.
  - The remaining buffer and in-flight data are flushed; no further issue.
  - halted = 1 and busy = 0 from the next cycle.
- Ignored inputs:
  - start in RUN is ignored.
  - br_valid in IDLE or HALTED is ignored.
  - If start and br_valid are both asserted in IDLE, start applies.
- Stalls: while out_valid & !out_ready, out_inst and out_pc are held stable.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds output port fetch_count [15:0].
  - Counts accepted instructions (deq), saturating at 16'hFFFF.
  - Cleared to 0 on reset and on an honoured start.
  - Flushed words are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Memory 0..3 = 0x11111111, 0x22222222, 0x33333333, 0xF0000000; start with start_addr = 0, out_ready = 1 -> out_inst 0x11111111..0xF0000000 on 4 consecutive cycles, out_pc 0..3. Then halted = 1, busy = 0, and no further out_valid.
- Same memory, out_ready toggling 1,0,0,1,... -> every word delivered exactly once, in order; out_inst stable while stalled; mem_addr never more than 2 ahead of the last accepted pc.
- Running from 0, assert br_valid with br_target = 0x10 while the word at pc 2 is valid -> pc 2 is not accepted and the in-flight pc 3 is dropped. Next out_pc = 0x10, then 0x11.
- Start with start_addr = 0xFE, ADDR_W = 8, no halt words -> out_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Assert rst_n = 0 for one cycle in RUN with out_valid = 1 -> next cycle out_valid = 0, busy = 0, mem_addr = RESET_PC. Then start with start_addr = 0 resumes from 0.
- With FETCH_PERF_EN: run the first scenario -> fetch_count = 4 after halt. Restart -> fetch_count = 0 and counts again.
